// File: rtl/irq_controller_if.sv
// CPU-side command/status bus for the interrupt controller at $7FFF.
interface irq_controller_if;
  logic       cs;
  logic       stb;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, stb, we, wdata, input rdata);
  modport slave  (input cs, stb, we, wdata, output rdata);
endinterface

// File: rtl/irq_controller.sv
// 6502 interrupt controller: per-source sync/edge/pending/enable lanes,
// a command/status byte and an active-low registered IRQ output.

module irq_src_lane (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic clr_pend,
  input  logic set_en,
  input  logic clr_en,
  output logic pend,
  output logic en
);
  logic s1, s2, h;
  logic rise;

  assign rise = s2 & ~h;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      h    <= 1'b0;
      pend <= 1'b0;
      en   <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      h  <= s2;
      // a fresh edge beats a same-cycle acknowledge
      if (rise)          pend <= 1'b1;
      else if (clr_pend) pend <= 1'b0;
      if (set_en)        en <= 1'b1;
      else if (clr_en)   en <= 1'b0;
    end
  end
endmodule

module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  irq_controller_if.slave    bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_n
);
  localparam logic [2:0] CMD_ACK     = 3'b000;
  localparam logic [2:0] CMD_ENABLE  = 3'b001;
  localparam logic [2:0] CMD_DISABLE = 3'b010;
  localparam logic [2:0] CMD_ACK_ALL = 3'b011;

  typedef enum logic [1:0] {
    VIEW_STATUS = 2'b00,
    VIEW_ENABLE = 2'b01,
    VIEW_RAW    = 2'b10,
    VIEW_VECTOR = 2'b11
  } view_t;

  logic               wr;
  logic [2:0]         cmd;
  logic [2:0]         idx;
  logic [NUM_SRC-1:0] clr_pend, set_en, clr_en;
  logic [NUM_SRC-1:0] pend, en, act;
  view_t              view;
  logic               vec_vld;
  logic [2:0]         vec_idx;
  logic [7:0]         rd_next;
  logic               unused_wdata;

  assign wr           = bus.cs & bus.stb & bus.we;
  assign cmd          = bus.wdata[7:5];
  assign idx          = bus.wdata[2:0];
  assign unused_wdata = ^bus.wdata[4:3];
  assign act          = pend & en;

  // idx beyond NUM_SRC never matches a lane, so those commands fall away
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    assign clr_pend[g] = wr & (((cmd == CMD_ACK) && (idx == 3'(g))) || (cmd == CMD_ACK_ALL));
    assign set_en[g]   = wr & (cmd == CMD_ENABLE)  & (idx == 3'(g));
    assign clr_en[g]   = wr & (cmd == CMD_DISABLE) & (idx == 3'(g));

    irq_src_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .src      (irq_src[g]),
      .clr_pend (clr_pend[g]),
      .set_en   (set_en[g]),
      .clr_en   (clr_en[g]),
      .pend     (pend[g]),
      .en       (en[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)             view <= VIEW_STATUS;
    else if (wr & cmd[2]) view <= view_t'(cmd[1:0]);
  end

  // scan downward so the lowest-numbered active source is left standing
  always_comb begin
    vec_vld = 1'b0;
    vec_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (act[i]) begin
        vec_vld = 1'b1;
        vec_idx = 3'(i);
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (view)
      VIEW_STATUS: rd_next = 8'(act);
      VIEW_ENABLE: rd_next = 8'(en);
      VIEW_RAW:    rd_next = 8'(pend);
      VIEW_VECTOR: rd_next = {vec_vld, 4'b0000, vec_idx};
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata <= 8'h00;
      irq_n     <= 1'b1;
    end else begin
      bus.rdata <= rd_next;
      irq_n     <= ~|act;
    end
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller behind the `irq_cs` chip select. The address decoder asserts `irq_cs` for $7FFF only.
- Collects up to 8 asynchronous, level-high interrupt requests from peripherals (UART, board IO, timers).
- Latches each rising edge as a pending bit, masks pending bits per source, and drives the 6502 active-low IRQ line.
- Software controls it through a single command/status byte at $7FFF.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..8). Unused upper bits of every read view read 0.

Ports:
- clk  in  1  system clock (one clock domain).
- rst  in  1  synchronous, active-high reset.
- cs  in  1  chip select from address decode (`irq_cs`).
- stb  in  1  one-cycle bus access qualifier; an access happens only on a cycle where cs & stb = 1.
- we  in  1  1 = CPU write, 0 = CPU read.
- wdata  in  8  CPU write data.
- rdata  out  8  CPU read data, registered.
- irq_src  in  NUM_SRC  asynchronous level-high interrupt requests.
- irq_n  out  1  active-low IRQ to CPU, registered.

Behaviour:
- Reset (rst=1 sampled at a clock edge) clears:
  - pending, enable, synchronizers and edge-detect history to 0;
  - view to STATUS; rdata to 0x00; irq_n to 1.
- Reset mid-operation discards any in-flight edge or command.
- Source path, per bit:
  - 2-flop synchronizer s1→s2, then history flop h (h<=s2).
  - Edge = s2 & ~h. Edge sets pending[i].
  - Timing: irq_src[i] rises before edge N → pending[i]=1 after edge N+2 → irq_n=0 after edge N+3.
  - A level held high causes only one pending set. A source must fall and rise again to re-trigger.
  - A source already high through reset produces one pending after reset, because the synchronizer resets to 0.
- Pending is latched regardless of enable. A disabled source's pending bit is retained and asserts IRQ once enabled.
- Write (cs&stb&we), effective at that clock edge. cmd = wdata[7:5], idx = wdata[2:0]:
  - 000 ACK: clear pending[idx].
  - 001 ENABLE: set enable[idx].
  - 010 DISABLE: clear enable[idx].
  - 011 ACK_ALL: clear all pending.
  - 100 view=STATUS; 101 view=ENABLE; 110 view=RAW; 111 view=VECTOR.
  - idx ≥ NUM_SRC: command ignored. View commands ignore idx.
- Simultaneous ACK (or ACK_ALL) and a new edge on the same source in the same cycle: set wins, pending stays 1.
- Read (cs&stb&~we) has no side effects. Reading never clears pending.
- rdata is updated every cycle from the current view and state, with one-cycle latency (reflects state after the previous edge):
  - STATUS = pending & enable.
  - ENABLE = enable.
  - RAW = pending.
  - VECTOR = {valid, 4'b0, index}, where index is the lowest-numbered set bit of pending & enable (bit 0 = highest priority). valid=0 and index=0 when none.
- irq_n <= ~|(pending & enable) every cycle. It deasserts one cycle after the ACK/DISABLE edge that clears the last active bit.
- Non-access cycles (cs=0 or stb=0) leave enable and view unchanged. Edges still set pending.
- All arithmetic is NUM_SRC-bit wide, zero-extended to 8 bits on read.

Test Plan:
1. Reset, then read:
   - STATUS, ENABLE and RAW views all read 0x00.
   - VECTOR view reads 0x00.
   - irq_n=1.
2. ENABLE src2 (wdata 0x22), pulse irq_src[2] high at edge N:
   - RAW=0x04 after N+2; irq_n=0 after N+3.
   - VECTOR reads 0x82.
   - ACK src2 (0x02) → irq_n=1 one cycle later.
3. Sources 5 and 1 pending, both enabled:
   - VECTOR=0x81.
   - ACK 1 → VECTOR=0x85.
   - ACK_ALL (0x60) → STATUS=0x00, irq_n=1.
4. Source 3 disabled, edge arrives:
   - RAW=0x08, STATUS=0x00, irq_n stays 1.
   - ENABLE 3 (0x23) → irq_n=0 next cycle.
5. Same-cycle ACK of src 0 and a new src 0 edge:
   - pending[0] remains 1, irq_n stays 0.
   - irq_src held high afterwards produces no second set after a later ACK.
6. Assert rst mid-sequence with irq_src=0xFF held high:
   - all state clears.
   - after release, RAW=0xFF within 3 cycles; irq_n stays 1 until enables are written.
   - cs=0 writes are ignored.
